// File: rtl/vga_timing_engine.sv
// Runtime-programmable VGA timing generator with frame-boundary commit of a shadow
// timing set, plus line/frame strobes and a frame counter for downstream generators.
module vga_timing_engine #(
  parameter int HW     = 12,
  parameter int PW     = 10,
  parameter int VPW    = 8,
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_POL  = 0,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_POL  = 0,
  localparam int CW    = HW + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_wr,
  input  logic [3:0]    cfg_addr,
  input  logic [15:0]   cfg_wdata,
  input  logic          cfg_commit,
  output logic          cfg_pending,
  output logic          hsync,
  output logic          vsync,
  output logic          display,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  typedef struct packed {
    logic [HW-1:0]  hdisp;
    logic [PW-1:0]  hfp;
    logic [PW-1:0]  hsw;
    logic           hpol;
    logic [PW-1:0]  hbp;
    logic [HW-1:0]  vdisp;
    logic [VPW-1:0] vfp;
    logic [VPW-1:0] vsw;
    logic           vpol;
    logic [VPW-1:0] vbp;
  } timing_t;

  localparam timing_t RESET_TIMING = '{
    hdisp: HW'(H_DISP), hfp: PW'(H_FP), hsw: PW'(H_SYNC), hpol: (H_POL != 0), hbp: PW'(H_BP),
    vdisp: HW'(V_DISP), vfp: VPW'(V_FP), vsw: VPW'(V_SYNC), vpol: (V_POL != 0), vbp: VPW'(V_BP)
  };

  timing_t       shadow;
  timing_t       live;
  logic          pend;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;

  logic [CW-1:0] h_disp_eff, h_sync_start, h_sync_end, h_total;
  logic [CW-1:0] v_disp_eff, v_sync_start, v_sync_end, v_total;
  logic          h_last, v_last, frame_wrap, frame_top, in_hsync, in_vsync;

  // Bits of cfg_wdata above the addressed field are deliberately discarded.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  // A zero display width would make the active area vanish; it is clamped to 1.
  always_comb begin
    h_disp_eff   = (live.hdisp == '0) ? CW'(1) : CW'(live.hdisp);
    h_sync_start = h_disp_eff + CW'(live.hfp);
    h_sync_end   = h_sync_start + CW'(live.hsw);
    h_total      = h_sync_end + CW'(live.hbp);
    v_disp_eff   = (live.vdisp == '0) ? CW'(1) : CW'(live.vdisp);
    v_sync_start = v_disp_eff + CW'(live.vfp);
    v_sync_end   = v_sync_start + CW'(live.vsw);
    v_total      = v_sync_end + CW'(live.vbp);
  end

  assign h_last     = (hc == h_total - CW'(1));
  assign v_last     = (vc == v_total - CW'(1));
  assign frame_wrap = h_last && v_last;
  assign frame_top  = (hc == '0) && (vc == '0);
  assign in_hsync   = (hc >= h_sync_start) && (hc < h_sync_end);
  assign in_vsync   = (vc >= v_sync_start) && (vc < v_sync_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= RESET_TIMING;
    end else if (cfg_wr) begin
      case (cfg_addr)
        4'd0: shadow.hdisp <= cfg_wdata[HW-1:0];
        4'd1: shadow.hfp   <= cfg_wdata[PW-1:0];
        4'd2: begin
          shadow.hsw  <= cfg_wdata[PW-1:0];
          shadow.hpol <= cfg_wdata[15];
        end
        4'd3: shadow.hbp   <= cfg_wdata[PW-1:0];
        4'd4: shadow.vdisp <= cfg_wdata[HW-1:0];
        4'd5: shadow.vfp   <= cfg_wdata[VPW-1:0];
        4'd6: begin
          shadow.vsw  <= cfg_wdata[VPW-1:0];
          shadow.vpol <= cfg_wdata[15];
        end
        4'd7: shadow.vbp   <= cfg_wdata[VPW-1:0];
        default: ;
      endcase
    end
  end

  // Counter stage: the live set only changes on the edge that returns to (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc   <= '0;
      vc   <= '0;
      live <= RESET_TIMING;
      pend <= 1'b0;
    end else begin
      if (h_last) begin
        hc <= '0;
        vc <= v_last ? '0 : vc + CW'(1);
      end else begin
        hc <= hc + CW'(1);
      end
      if (frame_wrap && pend) begin
        live <= shadow;
        pend <= 1'b0;
      end else if (cfg_commit) begin
        pend <= 1'b1;
      end
    end
  end

  // Output stage: decoded from the pre-advance counters, so every output lags by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~RESET_TIMING.hpol;
      vsync       <= ~RESET_TIMING.vpol;
      display     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
      cfg_pending <= 1'b0;
    end else begin
      hpos        <= hc;
      vpos        <= vc;
      hsync       <= in_hsync ~^ live.hpol;
      vsync       <= in_vsync ~^ live.vpol;
      display     <= (hc < h_disp_eff) && (vc < v_disp_eff);
      line_start  <= (hc == '0);
      frame_start <= frame_top;
      cfg_pending <= pend;
      if (frame_top) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_engine.sv
// Scoreboard bench for vga_timing_engine: directed cycle-indexed expectations are queued
// by the stimulus process and checked by an independent monitor on the falling edge.
module tb_vga_timing_engine;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [3:0]    cfg_addr = 4'd0;
  logic [15:0]   cfg_wdata = 16'd0;
  logic          cfg_commit = 1'b0;
  logic          cfg_pending, hsync, vsync, display, line_start, frame_start;
  logic [CW-1:0] hpos, vpos;
  logic [7:0]    frame_count;

  // Reduced reset timing: htotal 17 (sync 12..14), vtotal 10 (sync 7..8), 170 cycles per frame.
  vga_timing_engine #(
    .HW(12), .PW(10), .VPW(8),
    .H_DISP(10), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_POL(0),
    .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .V_POL(0)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .hsync(hsync), .vsync(vsync),
    .display(display), .hpos(hpos), .vpos(vpos), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  localparam int S_HPOS = 0, S_VPOS = 1, S_HS = 2, S_VS = 3, S_DISP = 4;
  localparam int S_LS = 5, S_FS = 6, S_FC = 7, S_PEND = 8, S_DCNT = 9;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   disp_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic void px(input int c, input int s, input int v, input string n);
    exp_t e;
    e.cyc = c; e.sel = s; e.val = v; e.name = n;
    sb.push_back(e);
  endfunction

  function automatic int actual(input int s);
    case (s)
      S_HPOS:  return int'(hpos);
      S_VPOS:  return int'(vpos);
      S_HS:    return int'(hsync);
      S_VS:    return int'(vsync);
      S_DISP:  return int'(display);
      S_LS:    return int'(line_start);
      S_FS:    return int'(frame_start);
      S_FC:    return int'(frame_count);
      S_PEND:  return int'(cfg_pending);
      default: return disp_cnt;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) disp_cnt = 0;
    else       disp_cnt = disp_cnt + int'(display);
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s @%0d: not sampled (now cycle %0d), expected %0d", e.name, e.cyc, cyc, e.val);
      end else if (actual(e.sel) != e.val) begin
        n_bad++;
        $display("FAIL %s @%0d: got %0d, expected %0d", e.name, e.cyc, actual(e.sel), e.val);
      end
    end
  end

  task automatic at_edge(input int e);
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int e, input logic [3:0] a, input logic [15:0] d);
    at_edge(e);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic commit(input int e);
    at_edge(e);
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  task automatic push_reset_state();
    px(0, S_HPOS, 0, "rst_hpos"); px(0, S_VPOS, 0, "rst_vpos");
    px(0, S_HS, 1, "rst_hsync");  px(0, S_VS, 1, "rst_vsync");
    px(0, S_DISP, 0, "rst_display"); px(0, S_LS, 0, "rst_line_start");
    px(0, S_FS, 0, "rst_frame_start"); px(0, S_FC, 0, "rst_frame_count");
    px(0, S_PEND, 0, "rst_pending");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    push_reset_state();
    // Default mode, frame 0
    px(1, S_HPOS, 0, "first_hpos"); px(1, S_VPOS, 0, "first_vpos"); px(1, S_DISP, 1, "first_display");
    px(1, S_LS, 1, "first_line_start"); px(1, S_FS, 1, "first_frame_start"); px(1, S_FC, 1, "first_count");
    px(1, S_HS, 1, "first_hsync"); px(1, S_VS, 1, "first_vsync");
    px(10, S_DISP, 1, "disp_h9"); px(11, S_DISP, 0, "disp_h10");
    px(12, S_HS, 1, "hs_h11"); px(13, S_HS, 0, "hs_h12"); px(15, S_HS, 0, "hs_h14"); px(16, S_HS, 1, "hs_h15");
    px(18, S_LS, 1, "ls_line1"); px(18, S_VPOS, 1, "vpos_line1"); px(18, S_HPOS, 0, "hpos_line1");
    px(95, S_DISP, 1, "disp_v5"); px(103, S_DISP, 0, "disp_v6");
    px(119, S_VS, 1, "vs_v6"); px(120, S_VS, 0, "vs_v7"); px(153, S_VS, 0, "vs_v8"); px(154, S_VS, 1, "vs_v9");
    px(170, S_HPOS, 16, "last_hpos"); px(170, S_VPOS, 9, "last_vpos"); px(170, S_FS, 0, "last_fs");
    px(170, S_DCNT, 60, "disp_count_f0");
    px(171, S_FS, 1, "fs_f1"); px(171, S_FC, 2, "fc_f1");
    // Shadow-only write of hdisplay=3 must not change frames 1 and 2
    px(174, S_DISP, 1, "shadow_iso_disp"); px(200, S_PEND, 0, "shadow_iso_pend");
    px(340, S_DCNT, 120, "disp_count_f1"); px(341, S_FS, 1, "fs_f2"); px(341, S_FC, 3, "fc_f2");
    px(357, S_HPOS, 16, "shadow_iso_hpos");
    px(511, S_FS, 1, "fs_f3"); px(511, S_FC, 4, "fc_f3"); px(511, S_PEND, 0, "pend_f3");
    // Mid-frame commit of small mode at vpos 5
    px(596, S_PEND, 0, "pend_at_commit"); px(596, S_VPOS, 5, "commit_vpos"); px(597, S_PEND, 1, "pend_after_commit");
    px(680, S_PEND, 1, "pend_frame_end"); px(680, S_HPOS, 16, "old_last_hpos"); px(680, S_VPOS, 9, "old_last_vpos");
    px(680, S_DCNT, 240, "disp_count_f3");
    px(681, S_FS, 1, "small_fs"); px(681, S_FC, 5, "small_fc"); px(681, S_PEND, 0, "small_pend_drop");
    px(681, S_HPOS, 0, "small_hpos0"); px(681, S_VPOS, 0, "small_vpos0");
    px(684, S_DISP, 1, "small_disp_h3"); px(685, S_DISP, 0, "small_disp_h4"); px(685, S_HS, 1, "small_hs_h4");
    px(686, S_HS, 0, "small_hs_h5"); px(687, S_HS, 0, "small_hs_h6"); px(688, S_HS, 1, "small_hs_h7");
    px(688, S_HPOS, 7, "small_hpos7");
    px(689, S_LS, 1, "small_ls"); px(689, S_VPOS, 1, "small_vpos1"); px(689, S_HPOS, 0, "small_wrap_h");
    px(712, S_VS, 1, "small_vs_v3"); px(713, S_VS, 0, "small_vs_v4"); px(721, S_VS, 1, "small_vs_v5");
    px(728, S_DCNT, 252, "disp_count_small"); px(728, S_HPOS, 7, "small_last_h"); px(728, S_VPOS, 5, "small_last_v");
    px(729, S_FS, 1, "small_fs2"); px(729, S_FC, 6, "small_fc2");
    // Polarity change committed during frame 5
    px(734, S_HS, 0, "pol_old_low"); px(740, S_PEND, 1, "pol_pending");
    px(777, S_PEND, 0, "pol_pend_drop"); px(777, S_FS, 1, "pol_fs"); px(777, S_FC, 7, "pol_fc");
    px(781, S_HS, 0, "pol_hs_h4"); px(782, S_HS, 1, "pol_hs_h5"); px(783, S_HS, 1, "pol_hs_h6"); px(784, S_HS, 0, "pol_hs_h7");
    px(808, S_VS, 0, "pol_vs_v3"); px(809, S_VS, 1, "pol_vs_v4");
    // Commit in the wrap cycle, removing hsync: applies one frame later
    px(824, S_HPOS, 7, "wrapc_hpos"); px(824, S_VPOS, 5, "wrapc_vpos"); px(824, S_PEND, 0, "wrapc_pend0");
    px(825, S_PEND, 1, "wrapc_pend1"); px(825, S_FS, 1, "wrapc_fs");
    px(830, S_HS, 1, "wrapc_pulse_kept"); px(850, S_PEND, 1, "wrapc_pend_mid"); px(872, S_PEND, 1, "wrapc_pend_end");
    px(873, S_PEND, 0, "wrapc_pend_drop"); px(873, S_FS, 1, "nosync_fs"); px(873, S_FC, 9, "nosync_fc");
    px(877, S_HS, 0, "nosync_h4"); px(878, S_HS, 0, "nosync_h5"); px(878, S_HPOS, 5, "nosync_hpos5");
    px(879, S_LS, 1, "nosync_ls"); px(879, S_VPOS, 1, "nosync_vpos1"); px(879, S_HPOS, 0, "nosync_hpos0");
    px(908, S_HPOS, 5, "nosync_last_h"); px(908, S_VPOS, 5, "nosync_last_v");
    px(909, S_FS, 1, "nosync_fs2"); px(909, S_FC, 10, "nosync_fc2");
    // One-cycle frames: frame_count wrap
    px(945, S_FS, 1, "tiny_fs"); px(945, S_FC, 11, "tiny_fc"); px(945, S_HPOS, 0, "tiny_hpos"); px(945, S_VPOS, 0, "tiny_vpos");
    px(1189, S_FC, 255, "fc_255");
    px(1190, S_FC, 0, "fc_wrap0"); px(1190, S_FS, 1, "fc_wrap_fs"); px(1190, S_HS, 0, "tiny_hs");
    px(1190, S_VS, 0, "tiny_vs"); px(1190, S_DISP, 1, "tiny_disp");
    px(1191, S_FC, 1, "fc_wrap1");

    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    wr(5, 4'd0, 16'd3);
    wr(520, 4'd0, 16'd4); wr(521, 4'd1, 16'd1); wr(522, 4'd2, 16'd2); wr(523, 4'd3, 16'd1);
    wr(524, 4'd4, 16'd3); wr(525, 4'd5, 16'd1); wr(526, 4'd6, 16'd1); wr(527, 4'd7, 16'd1);
    commit(596);
    wr(730, 4'd2, 16'h8002); wr(731, 4'd6, 16'h8001); commit(732);
    wr(800, 4'd2, 16'h8000); commit(824);
    wr(910, 4'd0, 16'd1); wr(911, 4'd1, 16'd0); wr(912, 4'd3, 16'd0); wr(913, 4'd4, 16'd1);
    wr(914, 4'd5, 16'd0); wr(915, 4'd6, 16'h8000); wr(916, 4'd7, 16'd0); commit(917);
    wr(918, 4'd9, 16'd5);
    wr(1195, 4'd0, 16'd5); commit(1196);

    // Asynchronous reset mid-cycle with a commit pending
    #2 reset = 1'b1;
    push_reset_state();
    px(1, S_FS, 1, "rr_fs"); px(1, S_FC, 1, "rr_fc"); px(1, S_DISP, 1, "rr_disp"); px(1, S_HPOS, 0, "rr_hpos");
    px(11, S_DISP, 0, "rr_disp_h10"); px(13, S_HS, 0, "rr_hs_h12"); px(50, S_PEND, 0, "rr_pend");
    px(120, S_VS, 0, "rr_vs_v7");
    px(170, S_HPOS, 16, "rr_last_h"); px(170, S_VPOS, 9, "rr_last_v"); px(170, S_PEND, 0, "rr_pend_end");
    px(171, S_FS, 1, "rr_fs2"); px(171, S_FC, 2, "rr_fc2");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    at_edge(176);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks never reached, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_engine.md
# vga_timing_engine

Parametrised, runtime-programmable VGA timing generator, successor to the fixed-width hvsync generator in the TinyVGA designs. It keeps a shadow copy of all ten timing fields written over a simple register port. The shadow set is committed to the live counters only at a frame boundary, so reprogramming never produces a torn frame. It also outputs line/frame strobes and a frame counter for the pattern generators downstream.

## Interface
- `HW`, 12: width of `hdisplay`/`vdisplay` fields.
- `PW`, 10: width of horizontal porch/sync fields.
- `VPW`, 8: width of vertical porch/sync fields.
- `H_DISP`/`H_FP`/`H_SYNC`/`H_BP`/`H_POL`, 640/16/96/48/0: reset horizontal timing.
- `V_DISP`/`V_FP`/`V_SYNC`/`V_BP`/`V_POL`, 480/10/2/33/0: reset vertical timing.
- Derived: `CW = HW+2` is the position counter width.
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_wr`  in  1  write strobe; writes `cfg_wdata` to shadow register `cfg_addr`.
- `cfg_addr`  in  4  register select.
- `cfg_wdata`  in  16  write data.
- `cfg_commit`  in  1  request shadow→live transfer at the next frame boundary.
- `cfg_pending`  out  1  commit requested, not yet applied.
- `hsync`, `vsync`  out  1  sync outputs, polarity applied.
- `display`  out  1  position is inside the active area.
- `hpos`, `vpos`  out  CW  current position.
- `line_start`  out  1  one-cycle pulse when `hpos`==0.
- `frame_start`  out  1  one-cycle pulse when `hpos`==0 and `vpos`==0.
- `frame_count`  out  8  frames started since reset; wraps 255→0.

## Operation
- Register map, fields taken from the LSBs of `cfg_wdata`, excess bits ignored:
  - 0 `hdisplay`[HW]; 1 `hfp`[PW]; 2 `hsync`[PW], bit15 `hpol`; 3 `hbp`[PW].
  - 4 `vdisplay`[HW]; 5 `vfp`[VPW]; 6 `vsync`[VPW], bit15 `vpol`; 7 `vbp`[VPW].
  - Addresses 8–15: writes ignored.
- Shadow and live sets reset to the parameter values.
- Writes touch only the shadow set; the live set drives the counters.
- `htotal = hdisplay+hfp+hsync+hbp` and `vtotal = vdisplay+vfp+vsync+vbp`, computed in CW bits from the live set. The programmer guarantees the totals fit in CW bits.
- A display field of 0 is treated as 1. Porch and sync fields of 0 are legal; sync length 0 means no sync pulse.
- Internal counter `hc` counts 0..htotal-1 and wraps. `vc` advances when `hc` wraps and counts 0..vtotal-1.
- Sync decode:
  - Horizontal sync region is `hdisplay+hfp <= hc < hdisplay+hfp+hsync`; `hsync = in_region XNOR hpol`, so `hpol`=0 gives an active-low pulse.
  - `vsync` is decoded the same way on `vc`.
- `display = (hc < hdisplay) && (vc < vdisplay)`.
- Commit handshake:
  - `cfg_commit` sets `cfg_pending`.
  - On the edge where `hc`,`vc` wrap from (htotal-1, vtotal-1) to (0,0) with `cfg_pending`=1, the live set is loaded from the shadow set and `cfg_pending` clears.
  - Writes issued while pending are still accepted and are included in that same commit.
  - A `cfg_wr` in the same cycle as `cfg_commit` is included.
  - `cfg_commit` asserted in the wrap cycle itself only sets pending; the transfer happens at the following boundary.
- Repeated `cfg_commit` while pending has no further effect.

## Timing
- Reset values (asynchronous):
  - `hc`=`vc`=0, `hpos`=`vpos`=0.
  - `hsync`=~`H_POL`, `vsync`=~`V_POL` (inactive levels).
  - `display`=0, `line_start`=`frame_start`=0, `frame_count`=0, `cfg_pending`=0.
- All outputs are registered from the pre-advance value of `hc`/`vc`. Output position therefore lags the internal counter by one cycle, and all outputs are mutually aligned.
- First edge after reset release: `hpos`=0, `vpos`=0, `display`=1, `line_start`=`frame_start`=1, and `frame_count` becomes 1.
- `frame_count` increments in the same cycle `frame_start` rises.
- New live timing first appears on outputs at the output cycle showing (0,0) of the new frame. The sync polarity change appears in that cycle as well.
- Reset asserted mid-frame: immediate return to reset values. Shadow and live sets revert to the parameters, and any pending commit is discarded.

## Test plan
- Default 640×480 after reset:
  - `hsync` is low exactly for `hpos` 656..751 and `vsync` low for `vpos` 490..491.
  - `frame_start` occurs every 420000 cycles.
  - `display` is high for 640×480 positions per frame.
- Small mode: write 4/1/2/1 horizontal and 3/1/1/1 vertical, then commit.
  - After the boundary: htotal 8 and vtotal 6.
  - `hsync` low at `hpos` 5,6 and `vsync` low at `vpos` 4.
- Shadow isolation: write `hdisplay`=100 without commit → timing unchanged for two full frames and `cfg_pending`=0.
- Mid-frame commit at `vpos`=200 → old timing continues to the end of the frame. The new timing starts exactly at the next `frame_start` and `cfg_pending` drops in that same cycle.
- Polarity: commit `hpol`=`vpol`=1 → sync pulses become active-high at the same positions.
- Edge cases: `cfg_commit` in the wrap cycle defers application by one frame; writing 0 to `hsync` removes the pulse; `frame_count` wraps 255→0; reset mid-frame with a commit pending → 640×480 resumes and pending is cleared.
